histogram_equalizer: RTL and testbench
======================================

# histogram_equalizer

Consumer of the histogram RAM filled each frame by the histogram stage. On `start`, walks all 256 bins, builds a cumulative-distribution lookup table into a shadow bank, then remaps the live 8-bit pixel stream through the active bank. Banks swap only at a frame boundary, so no frame is ever split between two mappings.

## Interface
- `FRAME_LOG2`, 16: log2 of pixels per frame; LUT scale shift; legal range 8..24.
- `CLIP_LIMIT`, 1024: per-bin clip ceiling; used only with the clip macro.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse requesting a LUT build.
- `hist_addr` out 8: histogram RAM read address.
- `hist_data` in 16: bin count; valid one cycle after `hist_addr`, registered RAM.
- `busy` out 1: high from the cycle after an accepted `start` until the end of the DONE cycle.
- `lut_ready` out 1: one-cycle pulse when the shadow bank is complete.
- `in_pixel` in 8, `in_valid` in 1, `end_of_frame` in 1: input pixel stream; `end_of_frame` is qualified by `in_valid`.
- `out_pixel` out 8, `out_valid` in→out 1, `out_end_of_frame` out 1: remapped stream.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ on `start`. Clears the accumulator and the swap-pending flag.
  - READ issues addresses 0..255, one per cycle, then moves to DRAIN.
  - DRAIN lasts 2 cycles to finish the last bin.
  - DONE lasts 1 cycle, pulses `lut_ready`, sets swap-pending, then returns to IDLE.
- `start` is ignored outside IDLE.
- Accumulator is 24 bits: `cdf += hist_data`. It cannot overflow (256 × 65535 < 2^24).
- LUT entry i = min(255, (cdf_i × 255) >> FRAME_LOG2).
  - cdf_i includes bin i.
  - The product is computed in 32 bits as (cdf << 8) − cdf.
- LUT is two banks of 256×8 bits. The build writes the inactive bank at entry i two cycles after address i is issued.
- Swap: on the cycle after `in_valid & end_of_frame`, if swap-pending is set, the active bank toggles and swap-pending clears.
  - If `lut_ready` and an end-of-frame land in the same cycle, the swap waits for the next end-of-frame.
- After reset, identity mode is active: `out_pixel = in_pixel`. Identity mode ends at the first swap.
- Reset mid-build aborts the build. LUT contents are not cleared, but no swap is pending, so the LUT is never used.

## Timing
- Reset values:
  - `hist_addr`, `out_pixel` = 0.
  - `busy`, `lut_ready`, `out_valid`, `out_end_of_frame` = 0.
  - FSM = IDLE, identity mode on, active bank 0.
- Build, with the `start` edge as cycle 0:
  - READ on cycles 1..256, `hist_addr` = cycle − 1.
  - DRAIN on cycles 257–258.
  - `lut_ready` high on cycle 259.
  - `busy` high on cycles 1..259.
- Pixel path: fixed 2-cycle latency. `out_valid` and `out_end_of_frame` are the inputs delayed by 2.
- The pixel path is independent of the FSM; a build never stalls the stream and needs no handshake.
- The swap affects the first pixel presented after the end-of-frame pixel.

## Configuration
- `HIST_EQ_CLIP_EN` defined:
  - Each `hist_data` is clipped to `min(hist_data, CLIP_LIMIT)` before accumulation.
  - The scale shift stays `FRAME_LOG2`; clipped excess simply darkens the mapping.
- Not defined: raw counts are accumulated and `CLIP_LIMIT` is unused.

## Test plan
- Reset, then pixel 0x37 with `in_valid` → `out_pixel` = 0x37, `out_valid` = 1, exactly 2 cycles later (identity).
- Uniform histogram, all bins = 256, `FRAME_LOG2` = 16; `start` at cycle 0, then end-of-frame:
  - `lut_ready` on cycle 259.
  - After the swap, inputs 0/127/255 map to 0/127/255.
- Single bin: hist[100] = 65535, all others 0; build then swap:
  - 99 → 0 and 100 → 254.
  - With `HIST_EQ_CLIP_EN` and `CLIP_LIMIT` = 1024: 100 → 3.
- Build completes mid-frame:
  - Pixels before end-of-frame still use the old mapping (identity).
  - The first pixel after end-of-frame uses the new LUT.
- Second `start` at cycle 100 of a build is ignored: exactly one `lut_ready`, still on cycle 259.
- `rst` low at cycle 50 of a build:
  - `busy` and `lut_ready` drop to 0 immediately.
  - The next end-of-frame causes no swap; identity is retained.

Source files
------------

// File: rtl/histogram_equalizer.sv
// Histogram equalizer: builds a CDF lookup table from the histogram RAM into a shadow bank
// and remaps the pixel stream through the active bank. Optional clip: define HIST_EQ_CLIP_EN.
//
// state | meaning
// IDLE  | waiting for start; pixel path keeps running on the active bank
// READ  | issuing histogram addresses 0..255, one per cycle
// DRAIN | two cycles to accumulate and write the last bin
// DONE  | shadow bank complete; pulse lut_ready, arm the frame-boundary swap
module histogram_equalizer #(
   parameter int FRAME_LOG2 = 16,
   parameter int CLIP_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  hist_addr,
   input  logic [15:0] hist_data,
   output logic        busy,
   output logic        lut_ready,
   input  logic [7:0]  in_pixel,
   input  logic        in_valid,
   input  logic        end_of_frame,
   output logic [7:0]  out_pixel,
   output logic        out_valid,
   output logic        out_end_of_frame
);

`ifdef HIST_EQ_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif
   localparam logic [15:0] CLIP_VAL = 16'(CLIP_LIMIT);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        drain_tmr;

   logic        rd_v;
   logic [7:0]  rd_idx;
   logic        wr_v;
   logic [7:0]  wr_idx;
   logic [23:0] cdf;
   logic [15:0] bin_cnt;
   logic [31:0] cdf_ext;
   logic [31:0] prod;
   logic [31:0] scaled;
   logic [7:0]  lut_val;

   logic        active_bank;
   logic        identity;
   logic        swap_pend;

   logic [7:0]  lut_mem [512];

   logic [7:0]  p1;
   logic        v1;
   logic        e1;
   logic        id1;
   logic        bank1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (hist_addr == 8'hFF) state_nxt = DRAIN;
         DRAIN:   if (drain_tmr == 1'b0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign lut_ready = (state == DONE);

   // drain_tmr is held loaded during READ and counts down through DRAIN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_addr <= 8'd0;
         drain_tmr <= 1'b0;
      end else begin
         hist_addr <= (state == READ) ? hist_addr + 8'd1 : 8'd0;
         if (state == READ)       drain_tmr <= 1'b1;
         else if (state == DRAIN) drain_tmr <= drain_tmr - 1'b1;
         else                     drain_tmr <= 1'b0;
      end
   end

   assign bin_cnt = (CLIP_EN && (hist_data > CLIP_VAL)) ? CLIP_VAL : hist_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_v   <= 1'b0;
         rd_idx <= 8'd0;
         wr_v   <= 1'b0;
         wr_idx <= 8'd0;
         cdf    <= 24'd0;
      end else begin
         rd_v   <= (state == READ);
         rd_idx <= hist_addr;
         wr_v   <= rd_v;
         wr_idx <= rd_idx;
         if (state == IDLE && start) cdf <= 24'd0;
         else if (rd_v)              cdf <= cdf + {8'd0, bin_cnt};
      end
   end

   // cdf * 255 without a multiplier; fits 32 bits since cdf < 2^24
   assign cdf_ext = {8'd0, cdf};
   assign prod    = (cdf_ext << 8) - cdf_ext;
   assign scaled  = prod >> FRAME_LOG2;
   assign lut_val = (scaled > 32'd255) ? 8'hFF : scaled[7:0];

   always_ff @(posedge clk) begin
      if (wr_v) lut_mem[{~active_bank, wr_idx}] <= lut_val;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_bank <= 1'b0;
         identity    <= 1'b1;
         swap_pend   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            swap_pend <= 1'b0;
         end else if (state == DONE) begin
            swap_pend <= 1'b1;
         end else if (in_valid && end_of_frame && swap_pend) begin
            active_bank <= ~active_bank;
            identity    <= 1'b0;
            swap_pend   <= 1'b0;
         end
      end
   end

   // Bank and identity are captured with the pixel so the end-of-frame pixel
   // still sees the mapping that was active when it arrived.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1               <= 8'd0;
         v1               <= 1'b0;
         e1               <= 1'b0;
         id1              <= 1'b1;
         bank1            <= 1'b0;
         out_pixel        <= 8'd0;
         out_valid        <= 1'b0;
         out_end_of_frame <= 1'b0;
      end else begin
         p1               <= in_pixel;
         v1               <= in_valid;
         e1               <= in_valid & end_of_frame;
         id1              <= identity;
         bank1            <= active_bank;
         out_pixel        <= id1 ? p1 : lut_mem[{bank1, p1}];
         out_valid        <= v1;
         out_end_of_frame <= e1;
      end
   end

endmodule

// File: tb/tb_histogram_equalizer.sv
// Scoreboard bench for histogram_equalizer: directed builds, frame-boundary swaps,
// ignored restart and mid-build reset.
module tb_histogram_equalizer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  hist_addr;
   logic [15:0] hist_data;
   logic        busy;
   logic        lut_ready;
   logic [7:0]  in_pixel = 8'd0;
   logic        in_valid = 1'b0;
   logic        end_of_frame = 1'b0;
   logic [7:0]  out_pixel;
   logic        out_valid;
   logic        out_end_of_frame;

   logic [15:0] hist_mem [256];

   typedef struct packed {
      logic [7:0] pix;
      logic       eof;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

`ifdef HIST_EQ_CLIP_EN
   localparam logic [7:0] EXP_HI = 8'd3;
`else
   localparam logic [7:0] EXP_HI = 8'd254;
`endif

   histogram_equalizer #(.FRAME_LOG2(16), .CLIP_LIMIT(1024)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .hist_addr        (hist_addr),
      .hist_data        (hist_data),
      .busy             (busy),
      .lut_ready        (lut_ready),
      .in_pixel         (in_pixel),
      .in_valid         (in_valid),
      .end_of_frame     (end_of_frame),
      .out_pixel        (out_pixel),
      .out_valid        (out_valid),
      .out_end_of_frame (out_end_of_frame)
   );

   always #5 clk = ~clk;

   always @(posedge clk) hist_data <= hist_mem[hist_addr];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic send_pix(input logic [7:0] p, input logic e, input logic [7:0] x);
      exp_t t;
      @(negedge clk);
      in_pixel     = p;
      in_valid     = 1'b1;
      end_of_frame = e;
      t.pix = x;
      t.eof = e;
      sb.push_back(t);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid     = 1'b0;
         end_of_frame = 1'b0;
      end
   endtask

   task automatic run_build(input int second_at, output int rdy_cnt, output int rdy_cyc);
      int busy_bad;
      int addr_bad;
      busy_bad = 0;
      addr_bad = 0;
      rdy_cnt  = 0;
      rdy_cyc  = -1;
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         start = (n == second_at);
         if (busy !== (n <= 259)) busy_bad++;
         if (hist_addr !== ((n <= 256) ? 8'(n - 1) : 8'd0)) addr_bad++;
         if (lut_ready === 1'b1) begin
            rdy_cnt++;
            rdy_cyc = n;
         end
      end
      start = 1'b0;
      chk("busy_window", busy_bad, 0);
      chk("hist_addr_sequence", addr_bad, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_pixel", int'(out_pixel), int'(e.pix));
               chk("out_end_of_frame", int'(out_end_of_frame), int'(e.eof));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int rc;
      int ry;
      int rc2;
      int ry2;
      int stray;

      for (int i = 0; i < 256; i++) hist_mem[i] = 16'd256;

      repeat (3) @(negedge clk);
      chk("reset_hist_addr", int'(hist_addr), 0);
      chk("reset_out_pixel", int'(out_pixel), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_lut_ready", int'(lut_ready), 0);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_eof", int'(out_end_of_frame), 0);
      rst = 1'b1;
      idle(2);

      // identity after reset, exact 2-cycle latency
      send_pix(8'h37, 1'b0, 8'h37);
      @(negedge clk);
      in_valid = 1'b0;
      chk("latency_not_early", int'(out_valid), 0);
      @(negedge clk);
      chk("latency_valid", int'(out_valid), 1);
      chk("latency_pixel", int'(out_pixel), 8'h37);
      idle(3);

      // uniform histogram
      run_build(0, rc, ry);
      chk("uniform_ready_count", rc, 1);
      chk("uniform_ready_cycle", ry, 259);
      send_pix(8'd10, 1'b1, 8'd10);
      send_pix(8'd0, 1'b0, 8'd0);
      send_pix(8'd127, 1'b0, 8'd127);
      send_pix(8'd255, 1'b0, 8'd255);
      idle(4);

      // single-bin histogram, built while the stream keeps running
      for (int i = 0; i < 256; i++) hist_mem[i] = 16'd0;
      hist_mem[100] = 16'hFFFF;
      fork
         run_build(0, rc, ry);
         begin
            repeat (140) begin
               send_pix(8'd99, 1'b0, 8'd99);
               send_pix(8'd100, 1'b0, 8'd100);
            end
            idle(1);
         end
      join
      chk("single_ready_count", rc, 1);
      chk("single_ready_cycle", ry, 259);
      send_pix(8'd100, 1'b1, 8'd100);
      send_pix(8'd99, 1'b0, 8'd0);
      send_pix(8'd100, 1'b0, EXP_HI);
      send_pix(8'd200, 1'b0, EXP_HI);
      send_pix(8'd0, 1'b0, 8'd0);
      idle(4);

      // second start during READ is ignored
      run_build(100, rc2, ry2);
      chk("restart_ready_count", rc2, 1);
      chk("restart_ready_cycle", ry2, 259);
      idle(2);

      // reset at cycle 50 of a build
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      chk("busy_before_reset", int'(busy), 1);
      rst = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_lut_ready", int'(lut_ready), 0);
      chk("abort_hist_addr", int'(hist_addr), 0);
      @(negedge clk);
      rst = 1'b1;
      stray = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (lut_ready !== 1'b0 || busy !== 1'b0) stray++;
      end
      chk("no_build_after_abort", stray, 0);
      send_pix(8'd50, 1'b1, 8'd50);
      send_pix(8'd55, 1'b0, 8'd55);
      send_pix(8'd150, 1'b0, 8'd150);
      idle(5);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
